// File: rtl/risc_core.sv
// Single-cycle RV32I subset core: fetch (f1), register file (d1) and data memory (m1).
// Instruction memory is loaded hierarchically; clk2 is a legacy phase input and is ignored.

module rc_imem #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic [7:0]  addr_i,
  output logic [31:0] data_o
);
  logic [31:0] IR_mem [IMEM_DEPTH];

  assign data_o = IR_mem[addr_i];
endmodule

module rc_fetch #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] instr_o
);
  logic [31:0] pc_q, pc_d;

  assign pc_d = pc_q + 32'd4;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  rc_imem #(.IMEM_DEPTH(IMEM_DEPTH)) IM (
    .addr_i (pc_q[9:2]),
    .data_o (instr_o)
  );
endmodule

module rc_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] reg_memory [32];

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) reg_memory[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      reg_memory[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : reg_memory[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : reg_memory[raddr2_i];
endmodule

module rc_decode (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_we_i,
  input  logic [31:0] rd_wdata_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);
  rc_regfile Register_File (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .raddr1_i (rs1_addr_i),
    .raddr2_i (rs2_addr_i),
    .waddr_i  (rd_addr_i),
    .we_i     (rd_we_i),
    .wdata_i  (rd_wdata_i),
    .rdata1_o (rs1_data_o),
    .rdata2_o (rs2_data_o)
  );
endmodule

module rc_dmem #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk_i,
  input  logic [7:0]  addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] mem [DMEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];
endmodule

module rc_memory #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk_i,
  input  logic [7:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic        store_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        load_ok_o
);
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  // Memory is word-indexed; SB/SH write a zero-extended full word.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (store_i) begin
      case (funct3_i)
        3'b000:  begin mem_we = 1'b1; mem_wdata = {24'd0, wdata_i[7:0]};  end
        3'b001:  begin mem_we = 1'b1; mem_wdata = {16'd0, wdata_i[15:0]}; end
        3'b010:  begin mem_we = 1'b1; mem_wdata = wdata_i;                end
        default: begin mem_we = 1'b0; mem_wdata = '0;                     end
      endcase
    end
  end

  always_comb begin
    rdata_o   = '0;
    load_ok_o = 1'b1;
    case (funct3_i)
      3'b000:  rdata_o = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  rdata_o = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b010:  rdata_o = mem_rdata;
      3'b100:  rdata_o = {24'd0, mem_rdata[7:0]};
      3'b101:  rdata_o = {16'd0, mem_rdata[15:0]};
      default: load_ok_o = 1'b0;
    endcase
  end

  rc_dmem #(.DMEM_DEPTH(DMEM_DEPTH)) Data_Memory (
    .clk_i   (clk_i),
    .addr_i  (addr_i),
    .we_i    (mem_we),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );
endmodule

module risc_core #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic rst,
  input logic clk1,
  input logic clk2
);
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic [31:0] instr, rs1_data, rs2_data, imm_i, imm_s;
  logic [31:0] alu_b, alu_res, ea, load_data, rd_wdata;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  shamt;
  logic        is_op, is_opimm, is_load, is_store, load_ok, rd_we;
  logic        unused_top;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_op    = (opcode == OPC_OP);
  assign is_opimm = (opcode == OPC_OPIMM);
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign ea       = rs1_data + (is_store ? imm_s : imm_i);
  assign alu_b    = is_op ? rs2_data : imm_i;
  assign shamt    = alu_b[4:0];
  assign unused_top = ^{clk2, ea[31:8]};

  rc_fetch #(.IMEM_DEPTH(IMEM_DEPTH)) f1 (
    .clk_i   (clk1),
    .rst_ni  (rst),
    .instr_o (instr)
  );

  rc_decode d1 (
    .clk_i      (clk1),
    .rst_ni     (rst),
    .rs1_addr_i (instr[19:15]),
    .rs2_addr_i (instr[24:20]),
    .rd_addr_i  (instr[11:7]),
    .rd_we_i    (rd_we),
    .rd_wdata_i (rd_wdata),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data)
  );

  rc_memory #(.DMEM_DEPTH(DMEM_DEPTH)) m1 (
    .clk_i     (clk1),
    .addr_i    (ea[7:0]),
    .funct3_i  (funct3),
    .store_i   (is_store),
    .wdata_i   (rs2_data),
    .rdata_o   (load_data),
    .load_ok_o (load_ok)
  );

  // instr[30] selects SUB only for register ops; for ADDI it is an immediate bit.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (is_op && instr[30]) ? rs1_data - alu_b : rs1_data + alu_b;
      3'b001:  alu_res = rs1_data << shamt;
      3'b010:  alu_res = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_data < alu_b};
      3'b100:  alu_res = rs1_data ^ alu_b;
      3'b101:  alu_res = instr[30] ? $unsigned($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
      3'b110:  alu_res = rs1_data | alu_b;
      default: alu_res = rs1_data & alu_b;
    endcase
  end

  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = '0;
    if (is_op || is_opimm) begin
      rd_we    = 1'b1;
      rd_wdata = alu_res;
    end else if (is_load) begin
      rd_we    = load_ok;
      rd_wdata = load_data;
    end
  end
endmodule

// File: tb/tb_risc_core.sv
// Directed bench for risc_core: table-driven program groups plus hand-written reset sequences.

module tb_risc_core;
  localparam int CK_NONE = 0;
  localparam int CK_REG  = 1;
  localparam int CK_MEM  = 2;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic rst, clk1, clk2;
  vec_t grp[$];
  int   n_checks, n_fail;
  logic [31:0] snap [256];

  risc_core #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .rst  (rst),
    .clk1 (clk1),
    .clk2 (clk2)
  );

  // clock/reset
  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  initial begin
    clk2 = 1'b1;
    forever #5 clk2 = ~clk2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required self-termination");
    $fatal(1, "bench timeout");
  end

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic void add(string name, logic [31:0] instr, int kind, int idx, logic [31:0] exp);
    vec_t v;
    v.name = name; v.instr = instr; v.kind = kind; v.idx = idx; v.exp = exp;
    grp.push_back(v);
  endfunction

  function automatic void add_setup();
    add("setup_x1", enc_i(12'h405, 5'd0, 3'b000, 5'd1, 7'h13), CK_REG, 1, 32'd1029);
    add("setup_x2", enc_i(12'h003, 5'd0, 3'b000, 5'd2, 7'h13), CK_REG, 2, 32'd3);
    add("setup_x3", enc_i(12'h7FD, 5'd0, 3'b000, 5'd3, 7'h13), CK_REG, 3, 32'd2045);
  endfunction

  // scoreboard
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // driver: reset, load grp into IR_mem, run 40 edges, compare every record
  task automatic run_group();
    @(negedge clk1);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) dut.f1.IM.IR_mem[i] = 32'd0;
    foreach (grp[i]) dut.f1.IM.IR_mem[i] = grp[i].instr;
    @(negedge clk1);
    rst = 1'b1;
    repeat (40) @(posedge clk1);
    @(negedge clk1);
    foreach (grp[i]) begin
      if (grp[i].kind == CK_REG)
        check(grp[i].name, dut.d1.Register_File.reg_memory[grp[i].idx], grp[i].exp);
      else if (grp[i].kind == CK_MEM)
        check(grp[i].name, dut.m1.Data_Memory.mem[grp[i].idx], grp[i].exp);
    end
  endtask

  task automatic count_nonzero_regs(output int cnt);
    cnt = 0;
    for (int r = 0; r < 32; r++)
      if (dut.d1.Register_File.reg_memory[r] !== 32'd0) cnt++;
  endtask

  initial begin
    int diff, nz;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;

    // reset state
    @(negedge clk1);
    rst = 1'b0;
    #1;
    check("reset_pc", dut.f1.pc_q, 32'd0);
    count_nonzero_regs(nz);
    check("reset_regs_nonzero", nz, 32'd0);

    // store group
    for (int i = 0; i < 256; i++) snap[i] = dut.m1.Data_Memory.mem[i];
    grp.delete();
    add_setup();
    add("sb_mem7",  enc_s(12'd4, 5'd1, 5'd2, 3'b000), CK_MEM, 7, 32'd5);
    add("sh_mem8",  enc_s(12'd5, 5'd1, 5'd2, 3'b001), CK_MEM, 8, 32'd1029);
    add("sw_mem10", enc_s(12'd7, 5'd1, 5'd2, 3'b010), CK_MEM, 10, 32'd1029);
    add("addi_m1",  enc_i(12'hFFF, 5'd0, 3'b000, 5'd12, 7'h13), CK_REG, 12, 32'hFFFF_FFFF);
    add("sb_zext",  enc_s(12'd20, 5'd12, 5'd0, 3'b000), CK_MEM, 20, 32'h0000_00FF);
    add("sh_zext",  enc_s(12'd21, 5'd12, 5'd0, 3'b001), CK_MEM, 21, 32'h0000_FFFF);
    add("sw_negoff", enc_s(12'hFFF, 5'd12, 5'd2, 3'b010), CK_MEM, 2, 32'hFFFF_FFFF);
    add("store_bad_f3", enc_s(12'd4, 5'd12, 5'd0, 3'b011), CK_NONE, 0, 32'd0);
    for (int r = 4; r <= 11; r++) add($sformatf("store_x%0d_zero", r), 32'd0, CK_REG, r, 32'd0);
    run_group();
    check("pc_after_40", dut.f1.pc_q, 32'd160);
    diff = 0;
    for (int i = 0; i < 256; i++)
      if (!(i inside {2, 7, 8, 10, 20, 21}) && dut.m1.Data_Memory.mem[i] !== snap[i]) diff++;
    check("mem_others_changed", diff, 32'd0);

    // I-type group
    grp.delete();
    add_setup();
    add("slti",  enc_i(12'hFFC, 5'd3, 3'b010, 5'd4, 7'h13), CK_REG, 4, 32'd0);
    add("sltiu", enc_i(12'hFFF, 5'd3, 3'b011, 5'd5, 7'h13), CK_REG, 5, 32'd1);
    add("xori",  enc_i(12'h001, 5'd3, 3'b100, 5'd6, 7'h13), CK_REG, 6, 32'd2044);
    add("ori",   enc_i(12'h001, 5'd3, 3'b110, 5'd7, 7'h13), CK_REG, 7, 32'd2045);
    add("andi",  enc_i(12'h001, 5'd3, 3'b111, 5'd8, 7'h13), CK_REG, 8, 32'd1);
    add("slli",  enc_i(12'h001, 5'd3, 3'b001, 5'd9, 7'h13), CK_REG, 9, 32'd4090);
    add("srli",  enc_i(12'h001, 5'd3, 3'b101, 5'd10, 7'h13), CK_REG, 10, 32'd1022);
    add("srai",  enc_i(12'h401, 5'd3, 3'b101, 5'd11, 7'h13), CK_REG, 11, 32'd1022);
    add("addi_min", enc_i(12'h800, 5'd3, 3'b000, 5'd12, 7'h13), CK_REG, 12, 32'hFFFF_FFFD);
    add("srai_neg", enc_i(12'h401, 5'd12, 3'b101, 5'd13, 7'h13), CK_REG, 13, 32'hFFFF_FFFE);
    add("srli_31",  enc_i(12'h01F, 5'd12, 3'b101, 5'd14, 7'h13), CK_REG, 14, 32'd1);
    add("x0_write", enc_i(12'h005, 5'd0, 3'b000, 5'd0, 7'h13), CK_REG, 0, 32'd0);
    add("x0_read_add", enc_r(7'h00, 5'd3, 5'd0, 3'b000, 5'd15), CK_REG, 15, 32'd2045);
    add("x0_read_sub", enc_r(7'h20, 5'd3, 5'd0, 3'b000, 5'd16), CK_REG, 16, 32'hFFFF_F803);
    add("lui_is_nop",  32'h12345A37, CK_REG, 20, 32'd0);
    run_group();

    // R-type group
    grp.delete();
    add_setup();
    add("add",  enc_r(7'h00, 5'd1, 5'd3, 3'b000, 5'd4), CK_REG, 4, 32'd3074);
    add("sub",  enc_r(7'h20, 5'd4, 5'd3, 3'b000, 5'd5), CK_REG, 5, 32'hFFFF_FBFB);
    add("sra",  enc_r(7'h20, 5'd2, 5'd5, 3'b101, 5'd9), CK_REG, 9, 32'hFFFF_FF7F);
    add("and",  enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd8), CK_REG, 8, 32'd1);
    add("sll",  enc_r(7'h00, 5'd1, 5'd4, 3'b001, 5'd6), CK_REG, 6, 32'd98368);
    add("slt",  enc_r(7'h00, 5'd2, 5'd5, 3'b010, 5'd7), CK_REG, 7, 32'd1);
    add("sltu", enc_r(7'h00, 5'd2, 5'd5, 3'b011, 5'd10), CK_REG, 10, 32'd0);
    add("srl",  enc_r(7'h00, 5'd2, 5'd5, 3'b101, 5'd11), CK_REG, 11, 32'h1FFF_FF7F);
    add("xor",  enc_r(7'h00, 5'd3, 5'd1, 3'b100, 5'd12), CK_REG, 12, 32'd1016);
    add("or",   enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd13), CK_REG, 13, 32'd1031);
    run_group();

    // mid-run reset: asynchronous clear, held through edges, then re-execution from IR_mem[0]
    repeat (3) @(posedge clk1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_pc", dut.f1.pc_q, 32'd0);
    count_nonzero_regs(nz);
    check("midrst_regs_nonzero", nz, 32'd0);
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    check("held_rst_pc", dut.f1.pc_q, 32'd0);
    check("held_rst_x4", dut.d1.Register_File.reg_memory[4], 32'd0);
    rst = 1'b1;
    @(posedge clk1);
    @(negedge clk1);
    check("restart_pc4", dut.f1.pc_q, 32'd4);
    check("restart_x1", dut.d1.Register_File.reg_memory[1], 32'd1029);
    check("restart_x2_pending", dut.d1.Register_File.reg_memory[2], 32'd0);
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    check("restart_pc12", dut.f1.pc_q, 32'd12);
    check("restart_x3", dut.d1.Register_File.reg_memory[3], 32'd2045);

    // load group: build 0x80F0, store it at mem[7], read it back every way
    grp.delete();
    add("mk_408",   enc_i(12'h408, 5'd0, 3'b000, 5'd1, 7'h13), CK_NONE, 0, 32'd0);
    add("mk_shift", enc_i(12'h005, 5'd1, 3'b001, 5'd1, 7'h13), CK_NONE, 0, 32'd0);
    add("mk_80f0",  enc_i(12'hFF0, 5'd1, 3'b000, 5'd1, 7'h13), CK_REG, 1, 32'h0000_80F0);
    add("ld_x2",    enc_i(12'h003, 5'd0, 3'b000, 5'd2, 7'h13), CK_REG, 2, 32'd3);
    add("preload",  enc_s(12'd4, 5'd1, 5'd2, 3'b010), CK_MEM, 7, 32'h0000_80F0);
    add("lb",  enc_i(12'd4, 5'd2, 3'b000, 5'd4, 7'h03), CK_REG, 4, 32'hFFFF_FFF0);
    add("lh",  enc_i(12'd4, 5'd2, 3'b001, 5'd5, 7'h03), CK_REG, 5, 32'hFFFF_80F0);
    add("lw",  enc_i(12'd4, 5'd2, 3'b010, 5'd6, 7'h03), CK_REG, 6, 32'h0000_80F0);
    add("lbu", enc_i(12'd4, 5'd2, 3'b100, 5'd7, 7'h03), CK_REG, 7, 32'h0000_00F0);
    add("lhu", enc_i(12'd4, 5'd2, 3'b101, 5'd8, 7'h03), CK_REG, 8, 32'h0000_80F0);
    add("ld_bad_f3_011", enc_i(12'd4, 5'd2, 3'b011, 5'd9, 7'h03), CK_REG, 9, 32'd0);
    add("ld_bad_f3_110", enc_i(12'd4, 5'd2, 3'b110, 5'd10, 7'h03), CK_REG, 10, 32'd0);
    run_group();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/risc_core.md
Name: risc_core

Overview:
- Single-cycle RV32I subset core: one instruction per rising clock edge.
- Sub-blocks (fixed instance names, for hierarchical preload and inspection):
  - f1: fetch, contains IM with array IR_mem.
  - d1: decode/register file, contains Register_File with array reg_memory.
  - m1: memory, contains Data_Memory with array mem.
- Top-level processor; instruction memory is preloaded hierarchically, with no external bus.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words in f1.IM.IR_mem.
- DMEM_DEPTH, 256, number of 32-bit data words in m1.Data_Memory.mem.

Ports:
- Declaration order is rst, clk1, clk2 (positional instantiation).
- clk1  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clk2  input  1  unused legacy phase input; ignored internally.

Behaviour:
- One clock (clk1); reset rst is asynchronous and active-low.
- Reset (rst=0, asynchronous):
  - PC=0.
  - All 32 reg_memory entries cleared to 0.
- Instruction and data memories:
  - Not reset; their contents are preserved.
  - Instruction fetch is combinational: instr = IR_mem[PC[9:2]].
- Each rising clk1 with rst=1:
  - PC <= PC+4, with 32-bit wrap.
  - Register write (if any) and data-memory write (if any) commit on the same edge.
- Register file:
  - 32x32; two combinational reads.
  - Writes to x0 are discarded; x0 always reads 0.
- Immediates are sign-extended:
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
- OP-IMM (opcode 0010011), rd <= rs1 op imm; funct3 selects:
  - 000 ADDI.
  - 010 SLTI (signed).
  - 011 SLTIU: unsigned compare against the sign-extended imm.
  - 100 XORI, 110 ORI, 111 ANDI.
  - 001 SLLI: shamt = imm[4:0].
  - 101 SRLI if instr[30]=0, SRAI if instr[30]=1.
- OP (opcode 0110011), rd <= rs1 op rs2, shift amount rs2[4:0]:
  - 000: ADD (instr[30]=0) / SUB (instr[30]=1).
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRL (instr[30]=0) / SRA (instr[30]=1).
  - 110 OR, 111 AND.
- Effective address for loads/stores: EA = rs1 + imm. Data memory is word-indexed by EA[7:0], with no byte lanes or alignment check.
- LOAD (opcode 0000011), combinational read of mem[EA[7:0]]; rd <=:
  - 000 LB: sign-extended [7:0].
  - 001 LH: sign-extended [15:0].
  - 010 LW: the full word.
  - 100 LBU: zero-extended [7:0].
  - 101 LHU: zero-extended [15:0].
  - Other funct3 values: no write.
- STORE (opcode 0100011), mem[EA[7:0]] <=:
  - 000 SB: zero-extended rs2[7:0].
  - 001 SH: zero-extended rs2[15:0].
  - 010 SW: rs2.
  - Other funct3 values: no write.
  - Stores never write the register file.
- Any other opcode, including 0x00000000 (unloaded memory): no-op, PC still advances. No branches, jumps, LUI or AUIPC.
- Arithmetic wraps modulo 2^32; no traps or overflow flags.
- Reset asserted mid-run: PC and registers clear immediately; execution restarts at IR_mem[0] on the first edge after release.

Test Plan:
- Immediate setup:
  - Stimulus: IR_mem[0..2] = ADDI x1,x0,0x405; ADDI x2,x0,3; ADDI x3,x0,0x7FD; rst 1→0→1; then 40 clk1 edges.
  - Required: x1=1029, x2=3, x3=2045.
- Stores (after the setup program):
  - Stimulus: IR_mem[3..5] = SB x1,4(x2); SH x1,5(x2); SW x1,7(x2).
  - Required: mem[7]=5, mem[8]=1029, mem[10]=1029; other mem words unchanged; x4..x11 remain 0.
- R-type (after the setup program):
  - Stimulus: ADD x4,x3,x1; SUB x5,x3,x4; SRA x9,x5,x2; AND x8,x1,x2; SLL x6,x4,x1; SLT x7,x5,x2.
  - Required: x4=3074, x5=0xFFFFFBFB, x9=0xFFFFFF7F, x8=1, x6=3074<<5=98368, x7=1.
- I-type (with x3=2045):
  - Stimulus: SLTI x4,x3,-4; SLTIU x5,x3,-1; XORI x6,x3,1; ORI x7,x3,1; ANDI x8,x3,1; SLLI x9,x3,1; SRLI x10,x3,1; SRAI x11,x3,1.
  - Required: x4=0, x5=1, x6=2044, x7=2045, x8=1, x9=4090, x10=1022, x11=1022.
- Loads:
  - Stimulus: preload mem[7]=0x000080F0; x2=3; LB x4,4(x2); LH x5,4(x2); LW x6,4(x2); LBU x7,4(x2); LHU x8,4(x2).
  - Required: x4=0xFFFFFFF0, x5=0xFFFF80F0, x6=0x000080F0, x7=0xF0, x8=0x80F0.
- x0 and reset:
  - Stimulus: ADDI x0,x0,5; then assert rst mid-program.
  - Required: x0 stays 0; PC=0 and all registers 0 immediately, without waiting for a clock edge; re-execution from IR_mem[0] after release.
